oci_dct_trace_packer: RTL and testbench
=======================================

Name: oci_dct_trace_packer

Overview:
- Sequences the OCI direct-compressed-trace (DCT) datapath.
- Accepts 2-bit branch atoms from the trace source and packs them into a 30-bit DCT buffer (up to 15 atoms).
- Hands completed frames to the trace FIFO over a valid/ready handshake; runs the end-of-test drain that raises test_has_ended.
- Sits between the Nios II trace-atom generator and the OCI trace memory. Its dct_buffer/dct_count/test_ending/test_has_ended outputs drive the OCI test-bench monitor.

Parameters:
- ATOM_W, 2, bits per atom.
- ATOMS, 15, atoms per full frame.
- CNT_W, 4, width of atom count; must satisfy 2^CNT_W > ATOMS.
- BUF_W, 30, derived ATOM_W*ATOMS, frame width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- atom_valid  in  1  source presents an atom.
- atom_data  in  ATOM_W  atom code.
- atom_ready  out  1  packer accepts the atom this cycle.
- flush_req  in  1  single-cycle pulse: close the partial frame (indirect branch/exception).
- test_ending  in  1  level: begin end-of-test drain.
- frame_valid  out  1  output frame register holds a frame.
- frame_ready  in  1  trace FIFO accepts the frame.
- frame_buffer  out  BUF_W  packed frame.
- frame_count  out  CNT_W  atoms in the frame, 1..15.
- dct_buffer  out  BUF_W  live accumulation buffer.
- dct_count  out  CNT_W  live atom count, 0..15.
- test_has_ended  out  1  sticky: drain complete.

Behaviour:
- Reset (async, immediate) clears all outputs and state:
  - dct_buffer=0, dct_count=0, frame_valid=0, frame_buffer=0, frame_count=0, test_has_ended=0, atom_ready=0 while reset is high.
  - pending flush is cleared; state=ACCUM.
- Accept rule: an atom is accepted when atom_valid & atom_ready.
  - Atom k (0-based) is written to dct_buffer[ATOM_W*k+1 : ATOM_W*k], LSB-first.
  - dct_count increments by 1.
  - Accepted at edge N, visible on dct_buffer/dct_count after edge N.
- Output register free = !frame_valid | frame_ready.
- Frame close occurs when any of these holds and the output register is free:
  - an accept makes the count reach ATOMS;
  - flush pending with dct_count>0;
  - drain with dct_count>0.
- Frame close action (same edge):
  - frame_buffer <= buffer including any atom accepted that edge;
  - frame_count <= resulting count; frame_valid <= 1;
  - dct_buffer <= 0; dct_count <= 0.
  - Frame is visible one cycle after the closing atom.
- Full / stall:
  - dct_count==ATOMS with the output register busy forces atom_ready=0.
  - The buffer never exceeds ATOMS; atoms are never dropped or overwritten.
- Flush:
  - flush_req latches flush_pending.
  - An atom accepted in the same cycle as flush_req is included in the flushed frame.
  - flush with dct_count==0 and no same-cycle atom produces no frame; flush_pending clears.
  - While flush_pending is set, atom_ready=0. It clears on frame close.
- frame_valid stays high, with frame_buffer/frame_count stable, until frame_ready is sampled high.
  - Handoff and a new close on the same edge are legal (back-to-back frames).
- State machine:
  - ACCUM: atom_ready = !flush_pending & !(full & busy). test_ending=1 -> DRAIN.
  - DRAIN: atom_ready=0. Close the partial frame when the output is free. When dct_count==0 and frame_valid==0 -> ENDED.
  - ENDED: test_has_ended=1, atom_ready=0. Stays until reset; test_ending is ignored.
  - Deassertion of test_ending in DRAIN does not abort the drain.
- Reset mid-frame discards the buffer and the output frame. No partial frame is emitted after reset.

Decomposition:
- Shared package oci_trace_pkg holds:
  - constants DCT_ATOM_W=2, DCT_ATOMS=15, DCT_BUF_W=30, DCT_CNT_W=4;
  - state enum {ACCUM, DRAIN, ENDED};
  - atom code constants (NT=2'b00, T=2'b01, reserved 10/11, passed through unchanged).
- One sub-module, oci_dct_frame_reg: the valid/ready output holding register (load, hold, handoff).

Test Plan:
- 15 atoms 01 back-to-back, frame_ready=1 -> frame_valid after cycle 15; frame_buffer=30'h15555555, frame_count=15; dct_count returns to 0.
- 3 atoms {00,01,01}, then flush_req -> frame_buffer=30'h14, frame_count=3; a flush with count 0 produces no frame.
- frame_ready=0 with 30 atoms offered -> the first frame is held stable; the second buffer fills to 15; atom_ready=0 on the 31st atom. Raising frame_ready releases both frames in order; no atom is lost.
- Atom 01 with flush_req in the same cycle at dct_count=2 -> frame_count=3; atom_ready=0 until the close.
- 5 atoms, then test_ending=1 -> frame_count=5 emitted; after handoff test_has_ended=1; it stays 1 after test_ending drops; further atoms are refused.
- reset pulse asserted mid-frame (dct_count=7, frame_valid=1) -> all outputs 0 immediately, asynchronously; the next 15 atoms form a clean frame.

Source files
------------

// File: rtl/oci_trace_pkg.sv
// Shared definitions for the OCI direct-compressed-trace (DCT) datapath.
//   - frame geometry constants (atom width, atoms per frame, derived widths)
//   - packer state encoding
//   - branch atom codes; the reserved codes 2'b10/2'b11 pass through unchanged
package oci_trace_pkg;

   localparam int unsigned DCT_ATOM_W = 2;
   localparam int unsigned DCT_ATOMS  = 15;
   localparam int unsigned DCT_CNT_W  = 4;
   localparam int unsigned DCT_BUF_W  = DCT_ATOM_W * DCT_ATOMS;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      ENDED = 2'd2
   } dct_state_e;

   localparam logic [DCT_ATOM_W-1:0] ATOM_NT    = 2'b00;
   localparam logic [DCT_ATOM_W-1:0] ATOM_T     = 2'b01;
   localparam logic [DCT_ATOM_W-1:0] ATOM_RSVD2 = 2'b10;
   localparam logic [DCT_ATOM_W-1:0] ATOM_RSVD3 = 2'b11;

endpackage

// File: rtl/oci_dct_trace_packer_if.sv
// Atom and frame streams of the DCT packer.
//   atom_valid/atom_data/atom_ready          : trace source -> packer
//   frame_valid/frame_ready/frame_buffer/count : packer -> trace FIFO
// master : the packer's view (accepts atoms, produces frames)
// slave  : the environment's view (trace source plus trace FIFO)
interface oci_dct_trace_packer_if #(
   parameter int unsigned ATOM_W = oci_trace_pkg::DCT_ATOM_W,
   parameter int unsigned CNT_W  = oci_trace_pkg::DCT_CNT_W,
   parameter int unsigned BUF_W  = oci_trace_pkg::DCT_BUF_W
);

   logic              atom_valid;
   logic [ATOM_W-1:0] atom_data;
   logic              atom_ready;
   logic              frame_valid;
   logic              frame_ready;
   logic [BUF_W-1:0]  frame_buffer;
   logic [CNT_W-1:0]  frame_count;

   modport master (
      input  atom_valid, atom_data, frame_ready,
      output atom_ready, frame_valid, frame_buffer, frame_count
   );

   modport slave (
      output atom_valid, atom_data, frame_ready,
      input  atom_ready, frame_valid, frame_buffer, frame_count
   );

endinterface

// File: rtl/oci_dct_frame_reg.sv
// Valid/ready output holding register for completed DCT frames.
//   clk, reset       : clock, asynchronous active-high reset
//   load_i           : capture buffer_i/count_i and raise valid_o
//   buffer_i/count_i : frame being closed
//   ready_i          : downstream accepts the held frame
//   valid_o          : a frame is held
//   buffer_o/count_o : held frame, stable while valid_o && !ready_i
//   free_o           : register may be loaded this cycle
module oci_dct_frame_reg #(
   parameter int unsigned BUF_W = 30,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [BUF_W-1:0] buffer_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [BUF_W-1:0] buffer_o,
   output logic [CNT_W-1:0] count_o,
   output logic             free_o
);

   logic             valid_q;
   logic [BUF_W-1:0] buffer_q;
   logic [CNT_W-1:0] count_q;

   // Load wins over handoff so a new frame can replace the one leaving on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q  <= 1'b0;
         buffer_q <= '0;
         count_q  <= '0;
      end else if (load_i) begin
         valid_q  <= 1'b1;
         buffer_q <= buffer_i;
         count_q  <= count_i;
      end else if (ready_i) begin
         valid_q  <= 1'b0;
      end
   end

   assign free_o   = !valid_q || ready_i;
   assign valid_o  = valid_q;
   assign buffer_o = buffer_q;
   assign count_o  = count_q;

endmodule

// File: rtl/oci_dct_trace_packer.sv
// Packs 2-bit branch atoms LSB-first into a 30-bit DCT buffer, closes frames on
// full/flush/drain and hands them to the trace FIFO; runs the end-of-test drain.
//   clk, reset     : clock, asynchronous active-high reset
//   bus (master)   : atom input stream and frame output stream
//   flush_req      : pulse, close the partial frame
//   test_ending    : level, start the end-of-test drain
//   dct_buffer     : live accumulation buffer
//   dct_count      : live atom count
//   test_has_ended : sticky, drain complete
module oci_dct_trace_packer
   import oci_trace_pkg::*;
#(
   parameter int unsigned ATOM_W = DCT_ATOM_W,
   parameter int unsigned ATOMS  = DCT_ATOMS,
   parameter int unsigned CNT_W  = DCT_CNT_W,
   parameter int unsigned BUF_W  = ATOM_W * ATOMS
) (
   input  logic                    clk,
   input  logic                    reset,
   oci_dct_trace_packer_if.master  bus,
   input  logic                    flush_req,
   input  logic                    test_ending,
   output logic [BUF_W-1:0]        dct_buffer,
   output logic [CNT_W-1:0]        dct_count,
   output logic                    test_has_ended
);

   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(ATOMS);

   dct_state_e       state_q, state_d;
   logic             flush_pending_q, flush_pending_d;
   logic [BUF_W-1:0] dct_buffer_q, dct_buffer_d;
   logic [CNT_W-1:0] dct_count_q, dct_count_d;
   logic             test_has_ended_q, test_has_ended_d;

   logic             frame_valid;
   logic             frame_free;
   logic             full;
   logic             atom_ready;
   logic             accept;
   logic             close;
   logic [BUF_W-1:0] atom_word;
   logic [BUF_W-1:0] ins_buffer;
   logic [CNT_W-1:0] ins_count;
   logic [BUF_W-1:0] close_buffer;
   logic [CNT_W-1:0] close_count;

   assign full      = (dct_count_q == FullCnt);
   assign atom_word = BUF_W'(bus.atom_data);

   // A full buffer may still take an atom when the output is free: the full frame
   // leaves on that edge and the new atom becomes atom 0 of the next buffer.
   always_comb begin
      atom_ready = 1'b0;
      if (!reset && state_q == ACCUM) begin
         atom_ready = !flush_pending_q && !(full && !frame_free);
      end
   end

   assign accept = bus.atom_valid && atom_ready;

   always_comb begin
      close        = 1'b0;
      close_buffer = dct_buffer_q;
      close_count  = dct_count_q;
      ins_buffer   = dct_buffer_q;
      ins_count    = dct_count_q;
      dct_buffer_d = dct_buffer_q;
      dct_count_d  = dct_count_q;

      if (full) begin
         close = frame_free;
         if (close) begin
            dct_buffer_d = accept ? atom_word : '0;
            dct_count_d  = CNT_W'(accept);
         end
      end else begin
         // Untouched slots are always zero, so OR-ing the atom in is sufficient.
         if (accept) begin
            ins_buffer = dct_buffer_q | (atom_word << (ATOM_W * 32'(dct_count_q)));
         end
         ins_count    = dct_count_q + CNT_W'(accept);
         close_buffer = ins_buffer;
         close_count  = ins_count;
         close        = frame_free && (ins_count != '0) &&
                        ((ins_count == FullCnt) || flush_pending_q || (state_q == DRAIN));
         dct_buffer_d = close ? '0 : ins_buffer;
         dct_count_d  = close ? '0 : ins_count;
      end
   end

   always_comb begin
      flush_pending_d = flush_pending_q;
      // An empty buffer has nothing to flush; drop the request without a frame.
      if (close || (flush_pending_q && dct_count_q == '0)) begin
         flush_pending_d = 1'b0;
      end
      if (flush_req && state_q == ACCUM) begin
         flush_pending_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM:   if (test_ending) state_d = DRAIN;
         DRAIN:   if (dct_count_q == '0 && !frame_valid) state_d = ENDED;
         ENDED:   state_d = ENDED;
         default: state_d = ACCUM;
      endcase
      test_has_ended_d = (state_d == ENDED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ACCUM;
         flush_pending_q  <= 1'b0;
         dct_buffer_q     <= '0;
         dct_count_q      <= '0;
         test_has_ended_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         flush_pending_q  <= flush_pending_d;
         dct_buffer_q     <= dct_buffer_d;
         dct_count_q      <= dct_count_d;
         test_has_ended_q <= test_has_ended_d;
      end
   end

   logic [BUF_W-1:0] frame_buffer;
   logic [CNT_W-1:0] frame_count;

   oci_dct_frame_reg #(
      .BUF_W (BUF_W),
      .CNT_W (CNT_W)
   ) u_frame_reg (
      .clk      (clk),
      .reset    (reset),
      .load_i   (close),
      .buffer_i (close_buffer),
      .count_i  (close_count),
      .ready_i  (bus.frame_ready),
      .valid_o  (frame_valid),
      .buffer_o (frame_buffer),
      .count_o  (frame_count),
      .free_o   (frame_free)
   );

   assign bus.atom_ready   = atom_ready;
   assign bus.frame_valid  = frame_valid;
   assign bus.frame_buffer = frame_buffer;
   assign bus.frame_count  = frame_count;

   assign dct_buffer     = dct_buffer_q;
   assign dct_count      = dct_count_q;
   assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_oci_dct_trace_packer.sv
module tb_oci_dct_trace_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_req;
   logic        test_ending;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_has_ended;

   int tests = 0;
   int fails = 0;

   oci_dct_trace_packer_if bus ();

   oci_dct_trace_packer dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .flush_req      (flush_req),
      .test_ending    (test_ending),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Offer one atom from a negedge and hold it until accepted (bounded).
   task automatic push_atom(input logic [1:0] d, output bit ok);
      int t;
      t  = 0;
      ok = 1'b0;
      @(negedge clk);
      bus.atom_valid = 1'b1;
      bus.atom_data  = d;
      #1;
      while (!bus.atom_ready && t < 40) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (bus.atom_ready) begin
         @(posedge clk);
         ok = 1'b1;
      end
      #1 bus.atom_valid = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [1:0] d, output int nfail);
      bit ok;
      nfail = 0;
      for (int i = 0; i < n; i++) begin
         push_atom(d, ok);
         if (!ok) nfail++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush_req = 1'b0;
      test_ending = 1'b0;
      bus.atom_valid = 1'b0;
      bus.atom_data = 2'b00;
      bus.frame_ready = 1'b1;
      cycle();
      cycle();
      tests++; if (bus.atom_ready !== 1'b0) begin fails++;
         $display("FAIL reset_atom_ready got %0b want 0", bus.atom_ready); end
      tests++; if (bus.frame_valid !== 1'b0) begin fails++;
         $display("FAIL reset_frame_valid got %0b want 0", bus.frame_valid); end
      tests++; if (dct_count !== 4'd0 || dct_buffer !== 30'd0) begin fails++;
         $display("FAIL reset_dct got %0d/%h want 0/0", dct_count, dct_buffer); end
      tests++; if (bus.frame_buffer !== 30'd0 || bus.frame_count !== 4'd0) begin fails++;
         $display("FAIL reset_frame got %h/%0d want 0/0", bus.frame_buffer, bus.frame_count); end
      tests++; if (test_has_ended !== 1'b0) begin fails++;
         $display("FAIL reset_ended got %0b want 0", test_has_ended); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++; if (bus.atom_ready !== 1'b1) begin fails++;
         $display("FAIL post_reset_ready got %0b want 1", bus.atom_ready); end
   endtask

   task automatic test_full_frame();
      int nf;
      push_n(15, 2'b01, nf);
      tests++; if (nf !== 0) begin fails++;
         $display("FAIL full_accept got %0d refused want 0", nf); end
      tests++; if (bus.frame_valid !== 1'b1) begin fails++;
         $display("FAIL full_valid got %0b want 1", bus.frame_valid); end
      tests++; if (bus.frame_buffer !== 30'h15555555) begin fails++;
         $display("FAIL full_buffer got %h want 15555555", bus.frame_buffer); end
      tests++; if (bus.frame_count !== 4'd15) begin fails++;
         $display("FAIL full_count got %0d want 15", bus.frame_count); end
      tests++; if (dct_count !== 4'd0 || dct_buffer !== 30'd0) begin fails++;
         $display("FAIL full_dct_clear got %0d/%h want 0/0", dct_count, dct_buffer); end
      cycle();
      tests++; if (bus.frame_valid !== 1'b0) begin fails++;
         $display("FAIL full_handoff got %0b want 0", bus.frame_valid); end
   endtask

   task automatic test_flush();
      bit ok0, ok1, ok2;
      bit seen;
      push_atom(2'b00, ok0);
      push_atom(2'b01, ok1);
      push_atom(2'b01, ok2);
      tests++; if (!(ok0 && ok1 && ok2) || dct_count !== 4'd3 || dct_buffer !== 30'h14) begin
         fails++;
         $display("FAIL flush_fill got %0d/%h want 3/14", dct_count, dct_buffer); end
      @(negedge clk); flush_req = 1'b1;
      cycle(); flush_req = 1'b0;
      tests++; if (bus.atom_ready !== 1'b0) begin fails++;
         $display("FAIL flush_pending_ready got %0b want 0", bus.atom_ready); end
      cycle();
      tests++; if (bus.frame_valid !== 1'b1 || bus.frame_buffer !== 30'h14 ||
                   bus.frame_count !== 4'd3) begin fails++;
         $display("FAIL flush_frame got %0b/%h/%0d want 1/14/3",
                  bus.frame_valid, bus.frame_buffer, bus.frame_count); end
      tests++; if (dct_count !== 4'd0) begin fails++;
         $display("FAIL flush_dct_clear got %0d want 0", dct_count); end
      cycle();
      @(negedge clk); flush_req = 1'b1;
      cycle(); flush_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (bus.frame_valid) seen = 1'b1;
      end
      tests++; if (seen !== 1'b0) begin fails++;
         $display("FAIL empty_flush_frame got %0b want 0", seen); end
      tests++; if (bus.atom_ready !== 1'b1) begin fails++;
         $display("FAIL empty_flush_ready got %0b want 1", bus.atom_ready); end
   endtask

   task automatic test_back_to_back();
      int nf1, nf2;
      @(negedge clk); bus.frame_ready = 1'b0;
      push_n(15, 2'b01, nf1);
      push_n(15, 2'b10, nf2);
      tests++; if (nf1 !== 0 || nf2 !== 0) begin fails++;
         $display("FAIL bp_accept got %0d/%0d refused want 0/0", nf1, nf2); end
      tests++; if (dct_count !== 4'd15 || dct_buffer !== 30'h2AAAAAAA) begin fails++;
         $display("FAIL bp_second_buf got %0d/%h want 15/2aaaaaaa", dct_count, dct_buffer); end
      tests++; if (bus.frame_valid !== 1'b1 || bus.frame_buffer !== 30'h15555555 ||
                   bus.frame_count !== 4'd15) begin fails++;
         $display("FAIL bp_held got %0b/%h/%0d want 1/15555555/15",
                  bus.frame_valid, bus.frame_buffer, bus.frame_count); end
      @(negedge clk); bus.atom_valid = 1'b1; bus.atom_data = 2'b11;
      cycle();
      tests++; if (bus.atom_ready !== 1'b0 || dct_count !== 4'd15) begin fails++;
         $display("FAIL bp_stall got %0b/%0d want 0/15", bus.atom_ready, dct_count); end
      @(negedge clk); bus.frame_ready = 1'b1;
      #1;
      tests++; if (bus.atom_ready !== 1'b1) begin fails++;
         $display("FAIL bp_release_ready got %0b want 1", bus.atom_ready); end
      @(posedge clk); #1 bus.atom_valid = 1'b0;
      tests++; if (bus.frame_valid !== 1'b1 || bus.frame_buffer !== 30'h2AAAAAAA ||
                   bus.frame_count !== 4'd15) begin fails++;
         $display("FAIL bp_second_frame got %0b/%h/%0d want 1/2aaaaaaa/15",
                  bus.frame_valid, bus.frame_buffer, bus.frame_count); end
      tests++; if (dct_count !== 4'd1 || dct_buffer !== 30'h3) begin fails++;
         $display("FAIL bp_31st_atom got %0d/%h want 1/3", dct_count, dct_buffer); end
      cycle();
      tests++; if (bus.frame_valid !== 1'b0) begin fails++;
         $display("FAIL bp_second_handoff got %0b want 0", bus.frame_valid); end
      @(negedge clk); flush_req = 1'b1;
      cycle(); flush_req = 1'b0;
      cycle();
      tests++; if (bus.frame_valid !== 1'b1 || bus.frame_buffer !== 30'h3 ||
                   bus.frame_count !== 4'd1) begin fails++;
         $display("FAIL bp_third_frame got %0b/%h/%0d want 1/3/1",
                  bus.frame_valid, bus.frame_buffer, bus.frame_count); end
      cycle();
   endtask

   task automatic test_flush_same_cycle();
      int nf;
      push_n(2, 2'b01, nf);
      @(negedge clk);
      bus.atom_valid = 1'b1; bus.atom_data = 2'b01; flush_req = 1'b1;
      #1;
      tests++; if (nf !== 0 || bus.atom_ready !== 1'b1) begin fails++;
         $display("FAIL same_pre got %0d/%0b want 0/1", nf, bus.atom_ready); end
      @(posedge clk); #1;
      bus.atom_valid = 1'b0; flush_req = 1'b0;
      tests++; if (dct_count !== 4'd3 || bus.atom_ready !== 1'b0) begin fails++;
         $display("FAIL same_pending got %0d/%0b want 3/0", dct_count, bus.atom_ready); end
      cycle();
      tests++; if (bus.frame_valid !== 1'b1 || bus.frame_count !== 4'd3 ||
                   bus.frame_buffer !== 30'h15) begin fails++;
         $display("FAIL same_frame got %0b/%0d/%h want 1/3/15",
                  bus.frame_valid, bus.frame_count, bus.frame_buffer); end
      tests++; if (bus.atom_ready !== 1'b1) begin fails++;
         $display("FAIL same_ready_after got %0b want 1", bus.atom_ready); end
      cycle();
   endtask

   task automatic test_drain();
      int nf, t;
      push_n(5, 2'b01, nf);
      @(negedge clk); test_ending = 1'b1;
      t = 0;
      cycle();
      while (!bus.frame_valid && t < 20) begin cycle(); t++; end
      tests++; if (nf !== 0 || bus.frame_valid !== 1'b1) begin fails++;
         $display("FAIL drain_frame_timeout got %0d/%0b want 0/1", nf, bus.frame_valid); end
      tests++; if (bus.frame_count !== 4'd5 || bus.frame_buffer !== 30'h155) begin fails++;
         $display("FAIL drain_frame got %0d/%h want 5/155", bus.frame_count, bus.frame_buffer);
      end
      @(negedge clk); test_ending = 1'b0;
      t = 0;
      while (!test_has_ended && t < 20) begin cycle(); t++; end
      tests++; if (test_has_ended !== 1'b1) begin fails++;
         $display("FAIL drain_ended_timeout got %0b want 1", test_has_ended); end
      @(negedge clk); bus.atom_valid = 1'b1; bus.atom_data = 2'b01;
      #1;
      tests++; if (bus.atom_ready !== 1'b0) begin fails++;
         $display("FAIL ended_ready got %0b want 0", bus.atom_ready); end
      for (int i = 0; i < 3; i++) cycle();
      tests++; if (test_has_ended !== 1'b1 || dct_count !== 4'd0 ||
                   bus.frame_valid !== 1'b0) begin fails++;
         $display("FAIL ended_sticky got %0b/%0d/%0b want 1/0/0",
                  test_has_ended, dct_count, bus.frame_valid); end
      bus.atom_valid = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int nf1, nf2, nf3;
      bit ok;
      @(negedge clk); reset = 1'b1;
      #2 reset = 1'b0;
      bus.frame_ready = 1'b0;
      push_n(15, 2'b01, nf1);
      push_n(7, 2'b01, nf2);
      tests++; if (nf1 !== 0 || nf2 !== 0 || dct_count !== 4'd7 ||
                   bus.frame_valid !== 1'b1) begin fails++;
         $display("FAIL mid_setup got %0d/%0d/%0d/%0b want 0/0/7/1",
                  nf1, nf2, dct_count, bus.frame_valid); end
      #2 reset = 1'b1;
      #1;
      tests++; if (dct_count !== 4'd0 || dct_buffer !== 30'd0 || bus.frame_valid !== 1'b0 ||
                   bus.frame_buffer !== 30'd0 || bus.frame_count !== 4'd0 ||
                   test_has_ended !== 1'b0 || bus.atom_ready !== 1'b0) begin fails++;
         $display("FAIL mid_async_reset got %0d/%h/%0b/%h/%0d/%0b/%0b want all 0",
                  dct_count, dct_buffer, bus.frame_valid, bus.frame_buffer,
                  bus.frame_count, test_has_ended, bus.atom_ready); end
      @(negedge clk); reset = 1'b0; bus.frame_ready = 1'b1;
      nf3 = 0;
      for (int i = 0; i < 15; i++) begin
         push_atom((i % 2 == 0) ? 2'b01 : 2'b00, ok);
         if (!ok) nf3++;
      end
      tests++; if (nf3 !== 0 || bus.frame_valid !== 1'b1 || bus.frame_buffer !== 30'h11111111 ||
                   bus.frame_count !== 4'd15) begin fails++;
         $display("FAIL mid_clean_frame got %0d/%0b/%h/%0d want 0/1/11111111/15",
                  nf3, bus.frame_valid, bus.frame_buffer, bus.frame_count); end
      cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_frame();
      test_flush();
      test_back_to_back();
      test_flush_same_cycle();
      test_drain();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
